sdram_traffic_master: RTL and testbench
=======================================

// Module: sdram_traffic_master
// PURPOSE
// SoC-side initiator for sdram_controller: drives soc_side_* request ports, writes a deterministic
// pattern over an address window, reads it back, compares, reports pass/fail and error statistics.
// Sits between a start/status register interface and the controller's SoC port; used for power-on
// memory test and as the synthesizable traffic source in board bring-up.
// PARAMETERS
// ADDR_WIDTH      23            word address width (8M x 32-bit)
// DATA_WIDTH      32            data word width; mask width = DATA_WIDTH/8
// START_ADDR      23'h000000    first word address tested
// NUM_WORDS       1024          words tested, 1..2^ADDR_WIDTH; window wraps modulo 2^ADDR_WIDTH
// SEED            32'hA5C3_0F1E pattern seed
// TIMEOUT_CYCLES  4096          max cycles waiting on any single handshake phase
// PORTS
// clk                        in   1   system clock (same as sdram_controller)
// reset_port                 in   1   synchronous, active-high reset
// start_port                 in   1   1-cycle pulse: begin test (ignored unless IDLE or DONE)
// done_port                  out  1   high from test end until next start/reset
// pass_port                  out  1   valid when done: no mismatch and no timeout
// timeout_port               out  1   sticky: a handshake phase exceeded TIMEOUT_CYCLES
// error_count_port           out  16  mismatching words, saturates at 16'hFFFF
// first_error_addr_port      out  23  address of first mismatch (0 if none)
// soc_side_busy_port         in   1   controller busy
// soc_side_ready_port        in   1   read data valid (1-cycle)
// soc_side_rd_data_port      in   32  read data
// soc_side_addr_port         out  23  word address
// soc_side_wr_data_port      out  32  write data
// soc_side_wr_mask_port      out  4   byte enables, always 4'b1111
// soc_side_wr_en_port        out  1   write request
// soc_side_rd_en_port        out  1   read request
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0. Reset mid-test aborts immediately, en ports 0 next edge.
// - pattern(a) = SEED ^ (zero-extended a * 32'h9E3779B1)[31:0]; pure function of address.
// - States: IDLE -> WR_REQ -> WR_WAIT -> (next addr) WR_REQ ... -> RD_REQ -> RD_WAIT -> ... -> DONE.
// - start in IDLE/DONE: clear done/pass/timeout/error_count/first_error_addr, addr=START_ADDR, go WR_REQ.
// - *_REQ: wait busy==0; then assert en with addr/data stable; hold until busy==1 seen, then en=0
//   same edge and go *_WAIT. Never wr_en and rd_en together.
// - WR_WAIT: leave when busy==0. RD_WAIT: capture rd_data on ready==1, compare, leave when busy==0
//   after ready seen. Mismatch: error_count+1 (saturating); first_error_addr set only on first.
// - Address increments by 1 mod 2^23 per word; word counter ends phase at NUM_WORDS.
// - Timeout: per-phase counter resets on each state entry; at TIMEOUT_CYCLES set timeout, en=0,
//   go DONE with pass=0.
// - DONE: done=1, pass=(error_count==0 && !timeout); start re-runs, else holds.
// - Latency: start to first wr_en = 1 cycle if busy==0.
// STRUCTURE
// - Shared package sdram_pkg: ADDR/DATA widths, state enum, pattern multiplier constant.
// - One sub-module: sdram_pattern_gen (combinational pattern(a)); FSM, counters, compare in top.
// TESTING (bench uses behavioral controller stub: busy 3 cycles after en, ready 1 cycle before busy falls)
// - Reset, then start with NUM_WORDS=4, START_ADDR=0, stub memory ideal -> 4 writes, 4 reads, done=1,
//   pass=1, error_count=0.
// - Stub flips bit 0 on read of addr 2 -> error_count=1, first_error_addr=2, pass=0.
// - START_ADDR=23'h7FFFFE, NUM_WORDS=4 -> addresses 7FFFFE,7FFFFF,000000,000001, pass=1.
// - Stub never raises busy, TIMEOUT_CYCLES=16 -> timeout=1, done=1, pass=0, en low within 17 cycles.
// - reset_port asserted during RD_WAIT -> next edge all outputs 0, state IDLE; new start runs clean.
// - start pulsed while busy (WR_WAIT) -> ignored; check wr_en/rd_en never both 1 throughout.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared widths, FSM states and pattern constant for the SDRAM traffic master.
package sdram_pkg;
  localparam int          ADDR_W   = 23;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] PAT_MULT = 32'h9E37_79B1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/sdram_pattern_gen.sv
// Address-keyed test pattern: SEED ^ (addr * PAT_MULT), low 32 bits.
module sdram_pattern_gen
  import sdram_pkg::*;
#(
  parameter int          ADDR_WIDTH = ADDR_W,
  parameter int          DATA_WIDTH = DATA_W,
  parameter logic [31:0] SEED       = 32'hA5C3_0F1E
)(
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [31:0] w_prod;

  assign w_prod = 32'(i_addr) * PAT_MULT;
  assign o_data = DATA_WIDTH'(SEED ^ w_prod);
endmodule

// File: rtl/sdram_traffic_master.sv
// Write/read-back memory tester driving the sdram_controller SoC port.
module sdram_traffic_master
  import sdram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = ADDR_W,
  parameter int                    DATA_WIDTH     = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
  parameter int                    NUM_WORDS      = 1024,
  parameter logic [31:0]           SEED           = 32'hA5C3_0F1E,
  parameter int                    TIMEOUT_CYCLES = 4096
)(
  input  logic                    clk,
  input  logic                    reset_port,
  input  logic                    start_port,
  output logic                    done_port,
  output logic                    pass_port,
  output logic                    timeout_port,
  output logic [15:0]             error_count_port,
  output logic [ADDR_WIDTH-1:0]   first_error_addr_port,
  input  logic                    soc_side_busy_port,
  input  logic                    soc_side_ready_port,
  input  logic [DATA_WIDTH-1:0]   soc_side_rd_data_port,
  output logic [ADDR_WIDTH-1:0]   soc_side_addr_port,
  output logic [DATA_WIDTH-1:0]   soc_side_wr_data_port,
  output logic [DATA_WIDTH/8-1:0] soc_side_wr_mask_port,
  output logic                    soc_side_wr_en_port,
  output logic                    soc_side_rd_en_port
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, r_first_err;
  logic [CNT_W-1:0]      r_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic [15:0]           r_err_cnt;
  logic                  r_wr_en, r_rd_en, r_rd_seen, r_timeout;
  logic                  w_wr_en_nxt, w_rd_en_nxt, w_done, w_pass;
  logic                  w_active, w_last, w_to_hit, w_to_fire, w_start_ok;
  logic                  w_capture, w_advance;
  logic [DATA_WIDTH-1:0] w_pattern;

  sdram_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SEED(SEED)
  ) u_pat (
    .i_addr(r_addr),
    .o_data(w_pattern)
  );

  assign w_active   = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT) ||
                      (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);
  assign w_last     = (r_cnt == CNT_W'(NUM_WORDS - 1));
  assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_start_ok = start_port && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_capture  = (r_state == S_RD_WAIT) && soc_side_ready_port && !r_rd_seen;
  assign w_advance  = ((r_state == S_WR_WAIT) || (r_state == S_RD_WAIT)) &&
                      (w_state_nxt != r_state) && !w_to_fire;

  always_ff @(posedge clk) begin
    if (reset_port) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_fire   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start_port) w_state_nxt = S_WR_REQ;
      S_WR_REQ:  if (r_wr_en && soc_side_busy_port) w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: if (!soc_side_busy_port) w_state_nxt = w_last ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ:  if (r_rd_en && soc_side_busy_port) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (r_rd_seen && !soc_side_busy_port) w_state_nxt = w_last ? S_DONE : S_RD_REQ;
      default:   w_state_nxt = S_IDLE;
    endcase
    // A phase that makes no progress for TIMEOUT_CYCLES aborts the whole test.
    if (w_active && (w_state_nxt == r_state) && w_to_hit) begin
      w_state_nxt = S_DONE;
      w_to_fire   = 1'b1;
    end
  end

  // Request enables are registered: raised on entry once the controller is idle, held until busy.
  always_comb begin
    w_wr_en_nxt = (w_state_nxt == S_WR_REQ) && (r_wr_en || !soc_side_busy_port);
    w_rd_en_nxt = (w_state_nxt == S_RD_REQ) && (r_rd_en || !soc_side_busy_port);
    w_done      = (r_state == S_DONE);
    w_pass      = w_done && (r_err_cnt == '0) && !r_timeout;
  end

  always_ff @(posedge clk) begin
    if (reset_port) begin
      r_addr      <= '0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_seen   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_wr_en <= w_wr_en_nxt;
      r_rd_en <= w_rd_en_nxt;
      if (w_state_nxt != r_state) r_to_cnt <= '0;
      else if (w_active)          r_to_cnt <= r_to_cnt + 1'b1;
      if (r_state != S_RD_WAIT)        r_rd_seen <= 1'b0;
      else if (soc_side_ready_port)    r_rd_seen <= 1'b1;
      if (w_to_fire) r_timeout <= 1'b1;
      if (w_capture && (soc_side_rd_data_port != w_pattern)) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt   <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0)       r_first_err <= r_addr;
      end
      if (w_advance) begin
        if (w_last) begin
          r_addr <= START_ADDR;
          r_cnt  <= '0;
        end else begin
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
      if (w_start_ok) begin
        r_timeout   <= 1'b0;
        r_err_cnt   <= '0;
        r_first_err <= '0;
        r_addr      <= START_ADDR;
        r_cnt       <= '0;
      end
    end
  end

  assign done_port             = w_done;
  assign pass_port             = w_pass;
  assign timeout_port          = r_timeout;
  assign error_count_port      = r_err_cnt;
  assign first_error_addr_port = r_first_err;
  assign soc_side_addr_port    = r_addr;
  assign soc_side_wr_data_port = r_wr_en ? w_pattern : '0;
  assign soc_side_wr_mask_port = '1;
  assign soc_side_wr_en_port   = r_wr_en;
  assign soc_side_rd_en_port   = r_rd_en;
endmodule

// File: tb/tb_sdram_traffic_master.sv
// Directed bench: two masters (window at 0 and wrapping window at 7FFFFE) against controller stubs.
module tb_sdram_traffic_master;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, done, pass, tmo, wr_en, rd_en;
  logic [1:0]  busy = '0, ready = '0, hang, flip, is_rd = '0;
  logic [15:0] errc [2];
  logic [22:0] fea [2], addr [2];
  logic [31:0] wdata [2], rdata [2] = '{32'd0, 32'd0}, rlatch [2];
  logic [3:0]  mask [2];
  logic [1:0]  cnt [2];
  logic [31:0] mem [2][16];
  logic [22:0] wlog_a [2][64], rlog_a [2][64];
  logic [31:0] wlog_d [2][64];
  int          nwr [2] = '{0, 0}, nrd [2] = '{0, 0}, both [2] = '{0, 0};
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  sdram_traffic_master #(.START_ADDR(23'h000000), .NUM_WORDS(4), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .reset_port(rst), .start_port(start[0]), .done_port(done[0]), .pass_port(pass[0]),
    .timeout_port(tmo[0]), .error_count_port(errc[0]), .first_error_addr_port(fea[0]),
    .soc_side_busy_port(busy[0]), .soc_side_ready_port(ready[0]), .soc_side_rd_data_port(rdata[0]),
    .soc_side_addr_port(addr[0]), .soc_side_wr_data_port(wdata[0]), .soc_side_wr_mask_port(mask[0]),
    .soc_side_wr_en_port(wr_en[0]), .soc_side_rd_en_port(rd_en[0]));

  sdram_traffic_master #(.START_ADDR(23'h7FFFFE), .NUM_WORDS(4), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .reset_port(rst), .start_port(start[1]), .done_port(done[1]), .pass_port(pass[1]),
    .timeout_port(tmo[1]), .error_count_port(errc[1]), .first_error_addr_port(fea[1]),
    .soc_side_busy_port(busy[1]), .soc_side_ready_port(ready[1]), .soc_side_rd_data_port(rdata[1]),
    .soc_side_addr_port(addr[1]), .soc_side_wr_data_port(wdata[1]), .soc_side_wr_mask_port(mask[1]),
    .soc_side_wr_en_port(wr_en[1]), .soc_side_rd_en_port(rd_en[1]));

  // Controller stub: busy for 3 cycles after accepting en, ready in the last busy cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wr_en[k] && rd_en[k]) both[k] <= both[k] + 1;
      if (!busy[k]) begin
        ready[k] <= 1'b0;
        if (!hang[k] && (wr_en[k] || rd_en[k])) begin
          busy[k]  <= 1'b1;
          cnt[k]   <= 2'd2;
          is_rd[k] <= rd_en[k];
          if (wr_en[k]) begin
            mem[k][addr[k][3:0]]   <= wdata[k];
            wlog_a[k][nwr[k] & 63] <= addr[k];
            wlog_d[k][nwr[k] & 63] <= wdata[k];
            nwr[k]                 <= nwr[k] + 1;
          end else begin
            rlatch[k] <= mem[k][addr[k][3:0]] ^ 32'(flip[k] && (addr[k] == 23'd2));
            rlog_a[k][nrd[k] & 63] <= addr[k];
            nrd[k]                 <= nrd[k] + 1;
          end
        end
      end else if (cnt[k] == 2'd0) begin
        busy[k]  <= 1'b0;
        ready[k] <= 1'b0;
      end else begin
        cnt[k] <= cnt[k] - 2'd1;
        if (cnt[k] == 2'd1 && is_rd[k]) begin
          ready[k] <= 1'b1;
          rdata[k] <= rlatch[k];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [22:0] a);
    logic [31:0] p;
    p = {9'd0, a} * 32'h9E37_79B1;
    return 32'hA5C3_0F1E ^ p;
  endfunction

  task automatic pulse_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input string tag);
    for (int i = 0; i < 400 && !done[k]; i++) @(negedge clk);
    chk(tag, done[k], 1);
  endtask

  task automatic wait_stub_idle(input int k);
    for (int i = 0; i < 20 && busy[k]; i++) @(negedge clk);
  endtask

  task automatic chk_window(input int k, input int bw, input int br, input logic [22:0] a0, input string tag);
    logic [22:0] a;
    for (int w = 0; w < 4; w++) begin
      a = a0 + 23'(w);
      chk($sformatf("%s wr_addr%0d", tag, w), 32'(wlog_a[k][(bw + w) & 63]), 32'(a));
      chk($sformatf("%s wr_data%0d", tag, w), wlog_d[k][(bw + w) & 63], pat(a));
      chk($sformatf("%s rd_addr%0d", tag, w), 32'(rlog_a[k][(br + w) & 63]), 32'(a));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bw, br, c;
    rst = 1'b1; start = '0; hang = '0; flip = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst done", 32'(done), 0);
    chk("rst pass", 32'(pass), 0);
    chk("rst timeout", 32'(tmo), 0);
    chk("rst en", 32'({wr_en, rd_en}), 0);
    chk("rst errc", 32'(errc[0]), 0);
    chk("rst fea", 32'(fea[0]), 0);
    chk("rst addr", 32'(addr[0]), 0);
    chk("rst wdata", wdata[0], 0);
    rst = 1'b0;

    // Ideal memory, window 0..3
    bw = nwr[0]; br = nrd[0];
    pulse_start(0);
    chk("t1 latency wr_en", 32'(wr_en[0]), 1);
    chk("t1 first addr", 32'(addr[0]), 0);
    chk("t1 first data", wdata[0], pat(23'd0));
    chk("t1 mask", 32'(mask[0]), 32'hF);
    wait_done(0, "t1 done");
    chk("t1 pass", 32'(pass[0]), 1);
    chk("t1 errc", 32'(errc[0]), 0);
    chk("t1 timeout", 32'(tmo[0]), 0);
    chk("t1 nwr", 32'(nwr[0] - bw), 4);
    chk("t1 nrd", 32'(nrd[0] - br), 4);
    chk_window(0, bw, br, 23'd0, "t1");

    // Bit 0 flipped on read of address 2
    flip[0] = 1'b1;
    pulse_start(0);
    chk("t2 done cleared", 32'(done[0]), 0);
    wait_done(0, "t2 done");
    chk("t2 errc", 32'(errc[0]), 1);
    chk("t2 fea", 32'(fea[0]), 2);
    chk("t2 pass", 32'(pass[0]), 0);
    flip[0] = 1'b0;

    // Window wrapping past the top of the address space
    bw = nwr[1]; br = nrd[1];
    pulse_start(1);
    chk("t3 first addr", 32'(addr[1]), 32'h7FFFFE);
    wait_done(1, "t3 done");
    chk("t3 pass", 32'(pass[1]), 1);
    chk("t3 errc", 32'(errc[1]), 0);
    chk_window(1, bw, br, 23'h7FFFFE, "t3");

    // Start pulsed during WR_WAIT must be ignored
    bw = nwr[1];
    pulse_start(1);
    c = 0;
    for (int i = 0; i < 20 && !(busy[1] && !wr_en[1] && !rd_en[1]); i++) begin
      @(negedge clk); c++;
    end
    chk("t4 reached wr_wait", 32'(busy[1] && !wr_en[1]), 1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1, "t4 done");
    chk("t4 nwr", 32'(nwr[1] - bw), 4);
    chk("t4 pass", 32'(pass[1]), 1);

    // Reset while a read is in flight (after the corrupted word was counted)
    flip[0] = 1'b1;
    br = nrd[0];
    pulse_start(0);
    for (int i = 0; i < 200 && !((nrd[0] - br) >= 4 && busy[0] && !rd_en[0]); i++) @(negedge clk);
    chk("t5 in rd_wait", 32'(busy[0] && !rd_en[0] && (nrd[0] - br) >= 4), 1);
    chk("t5 errc pre", 32'(errc[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5 en", 32'({wr_en, rd_en}), 0);
    chk("t5 done", 32'(done), 0);
    chk("t5 pass", 32'(pass), 0);
    chk("t5 errc", 32'(errc[0]), 0);
    chk("t5 fea", 32'(fea[0]), 0);
    chk("t5 addr", 32'(addr[0]), 0);
    rst = 1'b0;
    flip[0] = 1'b0;
    wait_stub_idle(0);
    pulse_start(0);
    wait_done(0, "t5 rerun done");
    chk("t5 rerun pass", 32'(pass[0]), 1);
    chk("t5 rerun errc", 32'(errc[0]), 0);

    // Controller never goes busy: timeout aborts the test
    wait_stub_idle(0);
    hang[0] = 1'b1;
    pulse_start(0);
    chk("t6 wr_en up", 32'(wr_en[0]), 1);
    c = 0;
    for (int i = 0; i < 40 && wr_en[0]; i++) begin
      c++;
      @(negedge clk);
    end
    chk("t6 en drop bound", 32'(c <= 17), 1);
    chk("t6 timeout", 32'(tmo[0]), 1);
    chk("t6 done", 32'(done[0]), 1);
    chk("t6 pass", 32'(pass[0]), 0);
    chk("t6 rd_en", 32'(rd_en[0]), 0);
    hang[0] = 1'b0;
    pulse_start(0);
    chk("t6 timeout cleared", 32'(tmo[0]), 0);
    wait_done(0, "t6 rerun done");
    chk("t6 rerun pass", 32'(pass[0]), 1);

    chk("both en dut0", 32'(both[0]), 0);
    chk("both en dut1", 32'(both[1]), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
